dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the core load/store unit (port 0) and the DMA/debug master (port 1). It provides per-cycle round-robin arbitration, an optional bounded lock for read-modify-write sequences, and write-alignment checking. Each granted access returns a registered one-cycle response. It sits between the masters and the data memory, driving the memory's `we`/`a`/`wd` inputs and sampling its combinational `rd`.

## Interface
- `LOCK_MAX`, default 4: maximum consecutive locked grants before a forced release when the other port is waiting; legal range 1..15.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `m0_req`, `m1_req` input 1: access request; must hold request fields stable until `gnt`.
- `m0_we`, `m1_we` input 2: 00 read, 01 word write, 10 half write, 11 byte write.
- `m0_addr`, `m1_addr` input 32: byte address.
- `m0_wd`, `m1_wd` input 32: write data, LSB-aligned for half/byte.
- `m0_lock`, `m1_lock` input 1: request to keep ownership for the next cycle.
- `m0_gnt`, `m1_gnt` output 1: combinational; the access is performed this cycle.
- `m0_rvalid`, `m1_rvalid` output 1: registered response strobe, 1 cycle.
- `m0_rdata`, `m1_rdata` output 32: registered read data.
- `m0_rerr`, `m1_rerr` output 1: registered; the access was rejected as misaligned.
- `mem_we` output 2: to memory write-enable, same encoding as `mX_we`.
- `mem_a` output 32: to memory address.
- `mem_wd` output 32: to memory write data.
- `mem_rd` input 32: memory combinational read data.

## Operation
- State: `last` (1 bit, last granted port), `owner_valid` + `owner` (lock holder), `lock_cnt` (4 bits), and per-port response registers.
- Arbitration each cycle, first matching rule wins:
  - Lock active (`owner_valid`, owner requesting, and not (`lock_cnt == LOCK_MAX` and the other port requesting)): grant owner.
  - Exactly one port requesting: grant that port.
  - Both requesting: grant `!last`.
  - Otherwise: no grant.
- At most one `gnt` is high in any cycle.
- On grant at the clock edge:
  - `last` <= granted port.
  - If `mX_lock` is high: `owner_valid` <= 1 and `owner` <= X. `lock_cnt` <= `lock_cnt` + 1 when X was already owner, else 1.
  - If `mX_lock` is low: `owner_valid` <= 0 and `lock_cnt` <= 0.
- Forced release: `owner_valid` <= 0 and `lock_cnt` <= 0 whenever the owner is not granted or drops `req`.
- Memory drive:
  - With a grant: `mem_a`, `mem_wd` and `mem_we` come from the granted port.
  - Idle: `mem_a` = 0, `mem_wd` = 0, `mem_we` = 00.
- Alignment check on writes:
  - Word write with `addr[1:0] != 0` is misaligned.
  - Half write with `addr[0] = 1` is misaligned.
  - A misaligned write is still granted (it consumes the slot), but `mem_we` is forced to 00.
  - Reads are never misaligned, because memory returns the full word.
- Response, registered one cycle after the grant cycle:
  - `rvalid` = 1 for one cycle.
  - `rdata` = `mem_rd` for reads, 0 for writes and for errors.
  - `rerr` = 1 only for a misaligned write.
  - The non-granted port's `rvalid` and `rerr` are 0 and its `rdata` holds its previous value.

## Timing
- Reset (async assert on `rst_n` = 0):
  - `last` = 1, so port 0 wins the first tie.
  - `owner_valid` = 0, `lock_cnt` = 0.
  - All `rvalid`, `rerr` and `rdata` = 0.
  - `mem_we` = 00 while reset is held.
- Grant-to-data latency: 0 cycles for writes (memory is written at the grant edge); 1 cycle for `rvalid`/`rdata`.
- Back-to-back: a port may be granted on consecutive cycles when it is the only requester or holds the lock. Throughput is 1 access/cycle total.
- Starvation bound: a waiting port is granted within `LOCK_MAX` + 1 cycles.
- Reset mid-lock clears ownership. A pending `rvalid` is dropped, not delivered.
- A requester must not change fields while `req` = 1 and `gnt` = 0. This is not checked.

## Test plan
- Reads and writes from a single port:
  - Stimulus: m0 word write `addr` = 0x10, `wd` = 0xDEADBEEF, then m0 read `addr` = 0x10.
  - Required: `m0_gnt` = 1 in each cycle. The read's `m0_rvalid` = 1 and `m0_rdata` = 0xDEADBEEF on the next cycle, with `rerr` = 0.
- Round-robin:
  - Stimulus: after reset, both ports request a read continuously for 4 cycles.
  - Required: grant order is 0, 1, 0, 1.
- Lock bound:
  - Stimulus: `LOCK_MAX` = 4; m1 holds `req` and `lock` with m0 requesting throughout.
  - Required: m1 is granted 4 cycles, then m0 is granted 1 cycle, then m1 regains the grant.
- Misalignment:
  - Stimulus: m1 half write `addr` = 0x21, then word write `addr` = 0x22.
  - Required: both are granted, `mem_we` = 00 in both cycles, `m1_rerr` = 1 in each following cycle, and memory is unchanged.
- Byte write then read:
  - Stimulus: m0 byte write `addr` = 0x13, `wd` = 0xAB over the word 0x11223344, then a read.
  - Required: `rdata` = 0xAB223344.
- Reset mid-lock:
  - Stimulus: assert `rst_n` = 0 while m0 owns the lock.
  - Required: all outputs are 0 immediately. After release, with both ports requesting, m0 is granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for the shared single-ported data memory, with a
// bounded read-modify-write lock, write-alignment checking and registered responses.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req,
  input  logic [1:0]  m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  input  logic        m0_lock,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_rerr,

  input  logic        m1_req,
  input  logic [1:0]  m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_rerr,

  output logic [1:0]  mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [3:0] LockMax = 4'(LOCK_MAX);

  localparam logic [1:0] WeRead = 2'b00;
  localparam logic [1:0] WeWord = 2'b01;
  localparam logic [1:0] WeHalf = 2'b10;

  // Arbitration and lock state
  logic       last_q, last_d;
  logic       owner_valid_q, owner_valid_d;
  logic       owner_q, owner_d;
  logic [3:0] lock_cnt_q, lock_cnt_d;

  // Per-port response registers
  logic        m0_rvalid_q, m1_rvalid_q;
  logic        m0_rerr_q, m1_rerr_q;
  logic [31:0] m0_rdata_q, m1_rdata_q;

  logic        owner_req, other_req, lock_hold;
  logic        gnt_any, gnt_sel;
  logic [1:0]  sel_we;
  logic [31:0] sel_addr, sel_wd;
  logic        sel_lock;
  logic        misaligned;
  logic [31:0] rsp_data;

  always_comb begin
    owner_req = owner_q ? m1_req : m0_req;
    other_req = owner_q ? m0_req : m1_req;
    lock_hold = owner_valid_q && owner_req && !((lock_cnt_q == LockMax) && other_req);

    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    // Grants are suppressed while reset is held so every output reads zero.
    if (rst_n) begin
      if (lock_hold) begin
        gnt_any = 1'b1;
        gnt_sel = owner_q;
      end else if (m0_req && !m1_req) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end else if (m1_req && !m0_req) begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end else if (m0_req && m1_req) begin
        gnt_any = 1'b1;
        gnt_sel = !last_q;
      end
    end
  end

  assign m0_gnt = gnt_any && !gnt_sel;
  assign m1_gnt = gnt_any && gnt_sel;

  always_comb begin
    sel_we   = gnt_sel ? m1_we   : m0_we;
    sel_addr = gnt_sel ? m1_addr : m0_addr;
    sel_wd   = gnt_sel ? m1_wd   : m0_wd;
    sel_lock = gnt_sel ? m1_lock : m0_lock;

    misaligned = ((sel_we == WeWord) && (sel_addr[1:0] != 2'b00)) ||
                 ((sel_we == WeHalf) && sel_addr[0]);
  end

  always_comb begin
    mem_we = WeRead;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt_any) begin
      mem_a  = sel_addr;
      mem_wd = sel_wd;
      // A misaligned write still consumes the slot but never reaches memory.
      mem_we = misaligned ? WeRead : sel_we;
    end
  end

  assign rsp_data = (sel_we == WeRead) ? mem_rd : '0;

  always_comb begin
    last_d        = last_q;
    owner_valid_d = 1'b0;
    owner_d       = owner_q;
    lock_cnt_d    = '0;
    if (gnt_any) begin
      last_d = gnt_sel;
      if (sel_lock) begin
        owner_valid_d = 1'b1;
        owner_d       = gnt_sel;
        if (owner_valid_q && (owner_q == gnt_sel)) begin
          // Saturate so an uncontested lock cannot wrap past the release threshold.
          lock_cnt_d = (lock_cnt_q == LockMax) ? lock_cnt_q : lock_cnt_q + 4'd1;
        end else begin
          lock_cnt_d = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q        <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_q       <= 1'b0;
      lock_cnt_q    <= '0;
    end else begin
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
      owner_q       <= owner_d;
      lock_cnt_q    <= lock_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m0_rerr_q   <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rvalid_q <= 1'b0;
      m1_rerr_q   <= 1'b0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= m0_gnt;
      m0_rerr_q   <= m0_gnt && misaligned;
      m1_rvalid_q <= m1_gnt;
      m1_rerr_q   <= m1_gnt && misaligned;
      if (m0_gnt) begin
        m0_rdata_q <= rsp_data;
      end
      if (m1_gnt) begin
        m1_rdata_q <= rsp_data;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m0_rerr   = m0_rerr_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m1_rerr   = m1_rerr_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-lane memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_lock, m0_gnt, m0_rvalid, m0_rerr;
  logic [1:0]  m0_we;
  logic [31:0] m0_addr, m0_wd, m0_rdata;
  logic        m1_req, m1_lock, m1_gnt, m1_rvalid, m1_rerr;
  logic [1:0]  m1_we;
  logic [31:0] m1_addr, m1_wd, m1_rdata;
  logic [1:0]  mem_we;
  logic [31:0] mem_a, mem_wd, mem_rd;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:63];

  dmem_arbiter #(.LOCK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd), .m0_lock(m0_lock),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rerr(m0_rerr),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd), .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rerr(m1_rerr),
    .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    case (mem_we)
      2'b01: mem[mem_a[7:2]] <= mem_wd;
      2'b10: begin
        if (mem_a[1]) mem[mem_a[7:2]][31:16] <= mem_wd[15:0];
        else          mem[mem_a[7:2]][15:0]  <= mem_wd[15:0];
      end
      2'b11: mem[mem_a[7:2]][{mem_a[1:0], 3'b000} +: 8] <= mem_wd[7:0];
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic req, input logic [1:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic lock);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wd = wd; m0_lock = lock;
  endtask

  task automatic drive1(input logic req, input logic [1:0] we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic lock);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wd = wd; m1_lock = lock;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive0(1'b1, 2'b01, 32'h4, 32'h5555_5555, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b00) begin
      n_errors++; $display("FAIL reset_gnt: got %b expected 00", {m0_gnt, m1_gnt});
    end
    n_checks++;
    if (mem_we !== 2'b00) begin
      n_errors++; $display("FAIL reset_mem_we: got %b expected 00", mem_we);
    end
    n_checks++;
    if ({m0_rvalid, m0_rerr, m1_rvalid, m1_rerr} !== 4'b0000) begin
      n_errors++;
      $display("FAIL reset_rsp: got %b expected 0000", {m0_rvalid, m0_rerr, m1_rvalid, m1_rerr});
    end
    n_checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      n_errors++; $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata);
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_rw();
    drive0(1'b1, 2'b01, 32'h10, 32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, mem_we, mem_a, mem_wd} !== {2'b10, 2'b01, 32'h10, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL rw_write_drive: got gnt=%b%b we=%b a=%h wd=%h expected gnt=10 we=01 a=10 wd=deadbeef",
               m0_gnt, m1_gnt, mem_we, mem_a, mem_wd);
    end
    tick();
    n_checks++;
    if ({m0_rvalid, m0_rerr, m0_rdata} !== {2'b10, 32'h0}) begin
      n_errors++;
      $display("FAIL rw_write_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=0", m0_rvalid, m0_rerr, m0_rdata);
    end
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, mem_we} !== 3'b100) begin
      n_errors++; $display("FAIL rw_read_gnt: got gnt=%b we=%b expected gnt=1 we=00", m0_gnt, mem_we);
    end
    tick();
    n_checks++;
    if ({m0_rvalid, m0_rerr, m0_rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      n_errors++;
      $display("FAIL rw_read_rsp: got v=%b e=%b d=%h expected v=1 e=0 d=deadbeef", m0_rvalid, m0_rerr, m0_rdata);
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, mem_we, mem_a} !== {1'b0, 2'b00, 32'h0}) begin
      n_errors++; $display("FAIL rw_idle: got gnt=%b we=%b a=%h expected 0 00 0", m0_gnt, mem_we, mem_a);
    end
    tick();
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin
      n_errors++; $display("FAIL rw_hold: got v=%b d=%h expected v=0 d=deadbeef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order;
    order = 4'b1010;  // bit i = 1 means port 1 expected on cycle i: 0,1,0,1
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    drive1(1'b1, 2'b00, 32'h20, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {!order[i], order[i]}) begin
        n_errors++;
        $display("FAIL rr_cycle%0d: got gnt=%b%b expected %b%b", i, m0_gnt, m1_gnt, !order[i], order[i]);
      end
      tick();
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_lock_bound();
    logic [5:0] order;
    order = 6'b101111;  // port per cycle from bit 0: 1,1,1,1,0,1
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    tick();  // m0 alone: last becomes 0
    drive1(1'b1, 2'b00, 32'h20, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({m0_gnt, m1_gnt} !== {!order[i], order[i]}) begin
        n_errors++;
        $display("FAIL lock_cycle%0d: got gnt=%b%b expected %b%b", i, m0_gnt, m1_gnt, !order[i], order[i]);
      end
      tick();
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_misalign();
    drive1(1'b1, 2'b01, 32'h20, 32'hCAFE_F00D, 1'b0);
    tick();
    drive1(1'b1, 2'b10, 32'h21, 32'h0000_1234, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, mem_we} !== 3'b100) begin
      n_errors++; $display("FAIL mis_half_drive: got gnt=%b we=%b expected gnt=1 we=00", m1_gnt, mem_we);
    end
    tick();
    n_checks++;
    if ({m1_rvalid, m1_rerr, m1_rdata} !== {2'b11, 32'h0}) begin
      n_errors++;
      $display("FAIL mis_half_rsp: got v=%b e=%b d=%h expected v=1 e=1 d=0", m1_rvalid, m1_rerr, m1_rdata);
    end
    drive1(1'b1, 2'b01, 32'h22, 32'h1111_2222, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, mem_we} !== 3'b100) begin
      n_errors++; $display("FAIL mis_word_drive: got gnt=%b we=%b expected gnt=1 we=00", m1_gnt, mem_we);
    end
    tick();
    n_checks++;
    if ({m1_rvalid, m1_rerr} !== 2'b11) begin
      n_errors++; $display("FAIL mis_word_rsp: got v=%b e=%b expected v=1 e=1", m1_rvalid, m1_rerr);
    end
    drive1(1'b1, 2'b00, 32'h20, 32'h0, 1'b0);
    tick();
    n_checks++;
    if ({m1_rvalid, m1_rerr, m1_rdata} !== {2'b10, 32'hCAFE_F00D}) begin
      n_errors++;
      $display("FAIL mis_mem_unchanged: got v=%b e=%b d=%h expected v=1 e=0 d=cafef00d",
               m1_rvalid, m1_rerr, m1_rdata);
    end
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_byte_write();
    drive0(1'b1, 2'b01, 32'h10, 32'h1122_3344, 1'b0);
    tick();
    drive0(1'b1, 2'b11, 32'h13, 32'h0000_00AB, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, mem_we} !== 3'b111) begin
      n_errors++; $display("FAIL byte_drive: got gnt=%b we=%b expected gnt=1 we=11", m0_gnt, mem_we);
    end
    tick();
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    tick();
    n_checks++;
    if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hAB22_3344}) begin
      n_errors++; $display("FAIL byte_readback: got v=%b d=%h expected v=1 d=ab223344", m0_rvalid, m0_rdata);
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_lock();
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b1);
    tick();
    tick();  // m0 owns the lock with a read response pending
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m0_rerr, m1_rvalid, m1_rerr, mem_we} !== 8'h00) begin
      n_errors++;
      $display("FAIL rml_ctrl_zero: got gnt=%b%b rsp=%b%b%b%b we=%b expected all 0",
               m0_gnt, m1_gnt, m0_rvalid, m0_rerr, m1_rvalid, m1_rerr, mem_we);
    end
    n_checks++;
    if ({m0_rdata, m1_rdata, mem_a, mem_wd} !== 128'h0) begin
      n_errors++;
      $display("FAIL rml_data_zero: got rd0=%h rd1=%h a=%h wd=%h expected all 0",
               m0_rdata, m1_rdata, mem_a, mem_wd);
    end
    tick();
    rst_n = 1'b1;
    drive0(1'b1, 2'b00, 32'h10, 32'h0, 1'b0);
    drive1(1'b1, 2'b00, 32'h20, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10) begin
      n_errors++; $display("FAIL rml_first: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b01) begin
      n_errors++; $display("FAIL rml_second: got gnt=%b%b expected 01", m0_gnt, m1_gnt);
    end
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    drive0(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    drive1(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_single_rw();
    test_round_robin();
    test_lock_bound();
    test_misalign();
    test_byte_write();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
